hci_core_per_adapter: RTL and testbench

// - Sits on the peripheral-side output of the HCI core memory-map filter.
// - Converts HCI core transactions into a flat, single-outstanding peripheral bus:
//   the request is registered, presented until granted, and the response is returned with the user field.
// - Optional timeout answers stalled transactions with an error beat, so the filter's ON_PER state can never hang.

---
 rtl/hci_core_per_adapter_pkg.sv | 18 +
 rtl/hci_core_intf.sv | 30 +++
 rtl/hci_core_per_timeout_cnt.sv | 33 +++
 rtl/hci_core_per_adapter.sv | 163 ++++++++++++++++
 tb/tb_hci_core_per_adapter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hci_core_per_adapter_pkg.sv
// Shared types and constants for the HCI core peripheral adapter: default bus widths,
// the adapter FSM state type and the word used to fill error responses.
package hci_core_per_adapter_pkg;

  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_UW = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    ERR_RSP
  } hci_per_adapter_state_t;

  localparam logic [31:0] HCI_PER_ERR_WORD = 32'hbadacce5;

endpackage

// File: rtl/hci_core_intf.sv
// Minimal HCI core request/response bundle as seen by the peripheral adapter.
interface hci_core_intf #(
  parameter int unsigned AW = hci_core_per_adapter_pkg::DEFAULT_AW,
  parameter int unsigned DW = hci_core_per_adapter_pkg::DEFAULT_DW,
  parameter int unsigned UW = hci_core_per_adapter_pkg::DEFAULT_UW
) ();

  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] be;
  logic [UW-1:0]   user;
  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic            r_opc;
  logic [UW-1:0]   r_user;

  modport slave (
    input  req, add, wen, data, be, user,
    output gnt, r_valid, r_data, r_opc, r_user
  );

  modport master (
    output req, add, wen, data, be, user,
    input  gnt, r_valid, r_data, r_opc, r_user
  );

endinterface

// File: rtl/hci_core_per_timeout_cnt.sv
// Saturating transaction-age counter for the peripheral adapter timeout.
// Only compiled when HCI_PER_ADAPTER_TIMEOUT_EN is defined.
`ifdef HCI_PER_ADAPTER_TIMEOUT_EN
module hci_core_per_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Holds at the limit so a grant exactly at the limit still times out if no response follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule
`endif

// File: rtl/hci_core_per_adapter.sv
// Bridges the HCI core filter's peripheral port onto a flat single-outstanding peripheral bus.
// Define HCI_PER_ADAPTER_TIMEOUT_EN to answer stalled transactions with an error beat.
module hci_core_per_adapter
  import hci_core_per_adapter_pkg::*;
#(
  parameter int unsigned AW             = DEFAULT_AW,
  parameter int unsigned DW             = DEFAULT_DW,
  parameter int unsigned UW             = DEFAULT_UW,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  hci_core_intf.slave     slave,
  output logic            per_req_o,
  output logic [AW-1:0]   per_add_o,
  output logic            per_wen_o,
  output logic [DW-1:0]   per_data_o,
  output logic [DW/8-1:0] per_be_o,
  input  logic            per_gnt_i,
  input  logic            per_r_valid_i,
  input  logic [DW-1:0]   per_r_data_i,
  input  logic            per_r_opc_i,
  output logic            busy_o,
  output logic            timeout_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (DW % 32 != 0) begin : g_bad_dw
    $error("DW must be a multiple of 32");
  end

  hci_per_adapter_state_t state, next_state;

  logic [AW-1:0]   cap_add;
  logic            cap_wen;
  logic [DW-1:0]   cap_data;
  logic [DW/8-1:0] cap_be;
  logic [UW-1:0]   cap_user;
  logic            accept;
  logic            expired;
  logic            timeout;

  // A new request is taken when idle, or in the response cycle so back-to-back beats need no idle gap.
  assign accept = slave.req && !clear_i &&
                  ((state == IDLE) || ((state == WAIT_RSP) && per_r_valid_i));

`ifdef HCI_PER_ADAPTER_TIMEOUT_EN
  logic active;
  assign active = (state == REQ) || (state == WAIT_RSP);

  hci_core_per_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (accept || clear_i),
    .enable  (active),
    .expired (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout <= 1'b0;
    end else if (clear_i) begin
      timeout <= 1'b0;
    end else if (next_state == ERR_RSP) begin
      timeout <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_add  <= '0;
      cap_wen  <= 1'b0;
      cap_data <= '0;
      cap_be   <= '0;
      cap_user <= '0;
    end else if (accept) begin
      cap_add  <= slave.add;
      cap_wen  <= slave.wen;
      cap_data <= slave.data;
      cap_be   <= slave.be;
      cap_user <= slave.user;
    end
  end

  // Grant and response take priority over an expiring counter in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = REQ;
      end
      REQ: begin
        if (per_gnt_i)    next_state = WAIT_RSP;
        else if (expired) next_state = ERR_RSP;
      end
      WAIT_RSP: begin
        if (per_r_valid_i) next_state = accept ? REQ : IDLE;
        else if (expired)  next_state = ERR_RSP;
      end
      ERR_RSP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (clear_i) next_state = IDLE;
  end

  always_comb begin
    per_req_o     = (state == REQ) && !clear_i;
    slave.gnt     = accept;
    slave.r_valid = 1'b0;
    slave.r_data  = '0;
    slave.r_opc   = 1'b0;
    slave.r_user  = '0;
    case (state)
      WAIT_RSP: begin
        if (per_r_valid_i && !clear_i) begin
          slave.r_valid = 1'b1;
          slave.r_data  = per_r_data_i;
          slave.r_opc   = per_r_opc_i;
          slave.r_user  = cap_user;
        end
      end
      ERR_RSP: begin
        if (!clear_i) begin
          slave.r_valid = 1'b1;
          slave.r_data  = {(DW/32){HCI_PER_ERR_WORD}};
          slave.r_opc   = 1'b1;
          slave.r_user  = cap_user;
        end
      end
      default: begin
      end
    endcase
  end

  assign per_add_o  = cap_add;
  assign per_wen_o  = cap_wen;
  assign per_data_o = cap_data;
  assign per_be_o   = cap_be;
  assign busy_o     = (state != IDLE);
  assign timeout_o  = timeout;

endmodule

// File: tb/tb_hci_core_per_adapter.sv
// Bench for hci_core_per_adapter: directed protocol scenarios followed by a randomized
// transaction stream scored at transaction level. Follows HCI_PER_ADAPTER_TIMEOUT_EN.
module tb_hci_core_per_adapter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 4;
  localparam int unsigned TIMEOUT_CYCLES = 8;
  localparam int NUM_RANDOM = 40;
  localparam int RANDOM_BUDGET = 3000;

  typedef struct {
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [UW-1:0]   user;
    int              gnt_delay;
    int              rsp_delay;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic per_req, per_wen, per_gnt, per_r_valid, per_r_opc, busy, timeout;
  logic [AW-1:0]   per_add;
  logic [DW-1:0]   per_data, per_r_data;
  logic [DW/8-1:0] per_be;

  int tests_run = 0;
  int tests_failed = 0;

  txn_t issued[$];
  txn_t cur_txn, per_txn;
  int   n_sent, n_done, gap, gnt_cnt, rsp_cnt;
  bit   per_active, rsp_pending, rnd_req, rnd_gnt, rnd_rvalid, rnd_opc;
  logic [DW-1:0] rnd_rdata;
  logic [UW-1:0] exp_user;
  int   silent_rvalid;

  hci_core_intf #(.AW(AW), .DW(DW), .UW(UW)) bus ();

  hci_core_per_adapter #(
    .AW(AW), .DW(DW), .UW(UW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .slave(bus),
    .per_req_o(per_req), .per_add_o(per_add), .per_wen_o(per_wen),
    .per_data_o(per_data), .per_be_o(per_be), .per_gnt_i(per_gnt),
    .per_r_valid_i(per_r_valid), .per_r_data_i(per_r_data), .per_r_opc_i(per_r_opc),
    .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [AW-1:0] add, input logic wen,
                               input logic [DW-1:0] data, input logic [DW/8-1:0] be, input logic [UW-1:0] user);
    bus.req  = req;
    bus.add  = add;
    bus.wen  = wen;
    bus.data = data;
    bus.be   = be;
    bus.user = user;
  endtask

  task automatic drivePeripheral(input logic gnt, input logic r_valid, input logic [DW-1:0] r_data, input logic r_opc);
    per_gnt     = gnt;
    per_r_valid = r_valid;
    per_r_data  = r_data;
    per_r_opc   = r_opc;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    drivePeripheral(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic txn_t newTxn();
    txn_t t;
    t.add       = AW'($urandom());
    t.wen       = 1'($urandom_range(0, 1));
    t.data      = DW'($urandom());
    t.be        = (DW/8)'($urandom_range(1, 15));
    t.user      = UW'($urandom_range(0, 15));
    t.gnt_delay = int'($urandom_range(0, 3));
    t.rsp_delay = int'($urandom_range(0, 2));
    return t;
  endfunction

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    idleInputs();
    nextCycle();
    nextCycle();
    settle();
    checkOutput("reset per_req", per_req, 0);
    checkOutput("reset gnt", bus.gnt, 0);
    checkOutput("reset r_valid", bus.r_valid, 0);
    checkOutput("reset r_data", bus.r_data, 0);
    checkOutput("reset r_opc", bus.r_opc, 0);
    checkOutput("reset r_user", bus.r_user, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset timeout", timeout, 0);
    checkOutput("reset per_add", per_add, 0);
    checkOutput("reset per_data", per_data, 0);
    rst = 1'b0;
    nextCycle();

    // Single read with a zero-wait peripheral.
    applyStimulus(1'b1, 32'h1000_0010, 1'b1, '0, 4'hf, 4'h3);
    settle();
    checkOutput("rd gnt c0", bus.gnt, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    drivePeripheral(1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("rd per_req c1", per_req, 1);
    checkOutput("rd per_add c1", per_add, 32'h1000_0010);
    checkOutput("rd per_wen c1", per_wen, 1);
    checkOutput("rd per_be c1", per_be, 4'hf);
    checkOutput("rd gnt c1", bus.gnt, 0);
    checkOutput("rd busy c1", busy, 1);
    nextCycle();
    drivePeripheral(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    settle();
    checkOutput("rd per_req c2", per_req, 0);
    checkOutput("rd r_valid c2", bus.r_valid, 1);
    checkOutput("rd r_data c2", bus.r_data, 32'hCAFE_F00D);
    checkOutput("rd r_opc c2", bus.r_opc, 0);
    checkOutput("rd r_user c2", bus.r_user, 4'h3);
    nextCycle();
    idleInputs();
    settle();
    checkOutput("rd busy c3", busy, 0);
    checkOutput("rd r_valid c3", bus.r_valid, 0);
    nextCycle();

    // Back-to-back writes: second request accepted in the first response cycle.
    applyStimulus(1'b1, 32'h20, 1'b0, 32'hD0D0_0001, 4'hf, 4'h1);
    settle();
    checkOutput("b2b gnt c0", bus.gnt, 1);
    nextCycle();
    applyStimulus(1'b1, 32'h24, 1'b0, 32'hD1D1_0002, 4'hc, 4'h2);
    drivePeripheral(1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("b2b per_add c1", per_add, 32'h20);
    checkOutput("b2b per_data c1", per_data, 32'hD0D0_0001);
    checkOutput("b2b per_wen c1", per_wen, 0);
    checkOutput("b2b gnt c1", bus.gnt, 0);
    nextCycle();
    drivePeripheral(1'b0, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("b2b r_valid c2", bus.r_valid, 1);
    checkOutput("b2b r_user c2", bus.r_user, 4'h1);
    checkOutput("b2b gnt c2", bus.gnt, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    drivePeripheral(1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("b2b per_req c3", per_req, 1);
    checkOutput("b2b per_add c3", per_add, 32'h24);
    checkOutput("b2b per_data c3", per_data, 32'hD1D1_0002);
    checkOutput("b2b per_be c3", per_be, 4'hc);
    nextCycle();
    drivePeripheral(1'b0, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("b2b r_valid c4", bus.r_valid, 1);
    checkOutput("b2b r_user c4", bus.r_user, 4'h2);
    nextCycle();
    idleInputs();
    settle();
    checkOutput("b2b busy c5", busy, 0);
    nextCycle();

    // Peripheral withholds its grant: request must stay stable and upstream stays blocked.
    applyStimulus(1'b1, 32'h300, 1'b0, 32'h55AA_55AA, 4'h3, 4'h5);
    nextCycle();
    applyStimulus(1'b1, 32'h999, 1'b1, 32'h0, 4'hf, 4'h9);
    for (int i = 0; i < 5; i++) begin
      settle();
      checkOutput("stall per_req", per_req, 1);
      checkOutput("stall per_add", per_add, 32'h300);
      checkOutput("stall per_data", per_data, 32'h55AA_55AA);
      checkOutput("stall per_be", per_be, 4'h3);
      checkOutput("stall gnt", bus.gnt, 0);
      nextCycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    drivePeripheral(1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("stall per_req at gnt", per_req, 1);
    nextCycle();
    drivePeripheral(1'b0, 1'b1, 32'h7777_0000, 1'b1);
    settle();
    checkOutput("stall r_valid", bus.r_valid, 1);
    checkOutput("stall r_data", bus.r_data, 32'h7777_0000);
    checkOutput("stall r_opc", bus.r_opc, 1);
    checkOutput("stall r_user", bus.r_user, 4'h5);
    nextCycle();
    idleInputs();

`ifdef HCI_PER_ADAPTER_TIMEOUT_EN
    // Grant arriving exactly on the limit cycle beats the timeout.
    applyStimulus(1'b1, 32'h40, 1'b1, '0, 4'hf, 4'h7);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    for (int i = 1; i < int'(TIMEOUT_CYCLES); i++) begin
      settle();
      checkOutput("limit per_req", per_req, 1);
      nextCycle();
    end
    drivePeripheral(1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("limit per_req last", per_req, 1);
    nextCycle();
    drivePeripheral(1'b0, 1'b1, 32'h1234_5678, 1'b0);
    settle();
    checkOutput("limit r_valid", bus.r_valid, 1);
    checkOutput("limit r_data", bus.r_data, 32'h1234_5678);
    checkOutput("limit r_opc", bus.r_opc, 0);
    checkOutput("limit timeout", timeout, 0);
    nextCycle();
    idleInputs();

    // Silent peripheral: error beat once the limit passes, late response dropped.
    applyStimulus(1'b1, 32'h50, 1'b1, '0, 4'hf, 4'h6);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < int'(TIMEOUT_CYCLES); i++) begin
      settle();
      checkOutput("to per_req", per_req, 1);
      checkOutput("to r_valid early", bus.r_valid, 0);
      nextCycle();
    end
    settle();
    checkOutput("to r_valid", bus.r_valid, 1);
    checkOutput("to r_data", bus.r_data, 32'hbadacce5);
    checkOutput("to r_opc", bus.r_opc, 1);
    checkOutput("to r_user", bus.r_user, 4'h6);
    checkOutput("to per_req err", per_req, 0);
    checkOutput("to timeout", timeout, 1);
    nextCycle();
    drivePeripheral(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    settle();
    checkOutput("to late r_valid", bus.r_valid, 0);
    checkOutput("to busy after", busy, 0);
    checkOutput("to timeout sticky", timeout, 1);
    nextCycle();
    idleInputs();
`else
    // Without the timeout a silent peripheral keeps the adapter busy indefinitely.
    applyStimulus(1'b1, 32'h50, 1'b1, '0, 4'hf, 4'h6);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    silent_rvalid = 0;
    for (int i = 0; i < 1000; i++) begin
      settle();
      if (bus.r_valid === 1'b1) silent_rvalid++;
      nextCycle();
    end
    settle();
    checkOutput("silent r_valid count", 64'(silent_rvalid), 0);
    checkOutput("silent busy", busy, 1);
    checkOutput("silent timeout", timeout, 0);
    checkOutput("silent per_req", per_req, 1);
    nextCycle();
    clear = 1'b1;
    nextCycle();
    clear = 1'b0;
    settle();
    checkOutput("silent busy after clear", busy, 0);
    nextCycle();
`endif

    // Soft clear while waiting for the response.
    applyStimulus(1'b1, 32'h60, 1'b1, '0, 4'hf, 4'h8);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    drivePeripheral(1'b1, 1'b0, '0, 1'b0);
    nextCycle();
    drivePeripheral(1'b0, 1'b0, '0, 1'b0);
    clear = 1'b1;
    settle();
    checkOutput("clr busy in wait", busy, 1);
    checkOutput("clr r_valid in wait", bus.r_valid, 0);
    nextCycle();
    clear = 1'b0;
    drivePeripheral(1'b0, 1'b1, 32'hABCD_0000, 1'b0);
    settle();
    checkOutput("clr busy after", busy, 0);
    checkOutput("clr late r_valid", bus.r_valid, 0);
    nextCycle();
    idleInputs();

    // Asynchronous reset in the middle of a request.
    applyStimulus(1'b1, 32'h70, 1'b0, 32'h1111_2222, 4'hf, 4'h4);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    settle();
    checkOutput("arst per_req before", per_req, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst per_req", per_req, 0);
    checkOutput("arst busy", busy, 0);
    checkOutput("arst per_add", per_add, 0);
    checkOutput("arst timeout", timeout, 0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    // Randomized stream: every request reaches the peripheral intact, every response returns with its user tag.
    n_sent = 0;
    n_done = 0;
    per_active = 1'b0;
    rsp_pending = 1'b0;
    gnt_cnt = 0;
    rsp_cnt = 0;
    exp_user = '0;
    cur_txn = newTxn();
    gap = int'($urandom_range(0, 2));
    for (int cyc = 0; cyc < RANDOM_BUDGET && n_done < NUM_RANDOM; cyc++) begin
      rnd_gnt = 1'b0;
      rnd_rvalid = 1'b0;
      rnd_rdata = DW'($urandom());
      rnd_opc = 1'b0;
      if (rsp_pending) begin
        if (rsp_cnt == 0) begin
          rnd_rvalid = 1'b1;
          rnd_opc = 1'($urandom_range(0, 1));
          exp_user = per_txn.user;
          rsp_pending = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
      if (per_req === 1'b1) begin
        if (!per_active) begin
          checkOutput("rnd request outstanding", 64'(issued.size() != 0), 1);
          if (issued.size() != 0) begin
            per_txn = issued.pop_front();
            gnt_cnt = per_txn.gnt_delay;
            per_active = 1'b1;
          end
        end
        if (per_active) begin
          checkOutput("rnd per_add", per_add, per_txn.add);
          checkOutput("rnd per_wen", per_wen, per_txn.wen);
          checkOutput("rnd per_data", per_data, per_txn.data);
          checkOutput("rnd per_be", per_be, per_txn.be);
          if (gnt_cnt == 0) begin
            rnd_gnt = 1'b1;
            per_active = 1'b0;
            rsp_pending = 1'b1;
            rsp_cnt = per_txn.rsp_delay;
          end else begin
            gnt_cnt--;
          end
        end
      end
      rnd_req = 1'b0;
      if (n_sent < NUM_RANDOM) begin
        if (gap == 0) rnd_req = 1'b1;
        else gap--;
      end
      applyStimulus(rnd_req, cur_txn.add, cur_txn.wen, cur_txn.data, cur_txn.be, cur_txn.user);
      drivePeripheral(rnd_gnt, rnd_rvalid, rnd_rdata, rnd_opc);
      settle();
      checkOutput("rnd r_valid", bus.r_valid, rnd_rvalid);
      if (rnd_rvalid) begin
        checkOutput("rnd r_data", bus.r_data, rnd_rdata);
        checkOutput("rnd r_opc", bus.r_opc, rnd_opc);
        checkOutput("rnd r_user", bus.r_user, exp_user);
        n_done++;
      end
      if (rnd_req && bus.gnt === 1'b1) begin
        issued.push_back(cur_txn);
        n_sent++;
        cur_txn = newTxn();
        gap = int'($urandom_range(0, 2));
      end
      nextCycle();
    end
    idleInputs();
    checkOutput("rnd completed", 64'(n_done), 64'(NUM_RANDOM));
    settle();
    checkOutput("rnd busy at end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
